// File: rtl/qft_accumulator_if.sv
// Term-in / bin-out streaming interface of the QFT bin accumulator.
// The master drives terms and out_ready; the slave returns bin results.
interface qft_accumulator_if #(
  parameter int DATA_W = 13,
  parameter int ACC_W  = 15
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_r;
  logic signed [DATA_W-1:0] in_i;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_r;
  logic signed [ACC_W-1:0]  out_i;
  logic [1:0]               out_bin;

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_bin
  );

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_bin
  );
endinterface

// File: rtl/qft_accumulator.sv
// Sums N_TERMS complex product terms into one QFT output bin at full precision,
// tagging each result with a wrapping bin index; one output holding register.
module qft_accumulator #(
  parameter int N_TERMS = 4,
  parameter int DATA_W  = 13,
  parameter int ACC_W   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  qft_accumulator_if.slave  bus
);

  localparam logic [1:0] CNT_LAST = 2'(N_TERMS - 1);

  typedef enum logic {IDLE, ACC} state_t;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] v);
    return ACC_W'(v);
  endfunction

  state_t                  r_state;
  logic [1:0]              r_cnt;
  logic [1:0]              r_bin_idx;
  logic signed [ACC_W-1:0] r_acc_r;
  logic signed [ACC_W-1:0] r_acc_i;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_r;
  logic signed [ACC_W-1:0] r_out_i;
  logic [1:0]              r_out_bin;

  logic                    w_last_slot;
  logic                    w_in_ready;
  logic                    w_accept;
  logic signed [ACC_W-1:0] w_sum_r;
  logic signed [ACC_W-1:0] w_sum_i;

  // Input stage: only the closing term of a frame can be blocked by a stuck result.
  assign w_last_slot = (r_state == ACC) && (r_cnt == CNT_LAST);
  assign w_in_ready  = !(w_last_slot && r_out_valid && !bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready && !flush;
  assign w_sum_r     = r_acc_r + sext(bus.in_r);
  assign w_sum_i     = r_acc_i + sext(bus.in_i);

  // Accumulate / output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bin_idx   <= '0;
      r_acc_r     <= '0;
      r_acc_i     <= '0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_out_bin   <= '0;
    end else begin
      if (r_out_valid && bus.out_ready)
        r_out_valid <= 1'b0;

      if (flush) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_bin_idx <= '0;
        r_acc_r   <= '0;
        r_acc_i   <= '0;
      end else if (w_accept) begin
        if (w_last_slot) begin
          // A new result overrides the consume-clear above on the same edge.
          r_out_r     <= w_sum_r;
          r_out_i     <= w_sum_i;
          r_out_bin   <= r_bin_idx;
          r_out_valid <= 1'b1;
          r_bin_idx   <= r_bin_idx + 2'd1;
          r_acc_r     <= '0;
          r_acc_i     <= '0;
          r_cnt       <= '0;
          r_state     <= IDLE;
        end else begin
          r_acc_r <= w_sum_r;
          r_acc_i <= w_sum_i;
          r_cnt   <= r_cnt + 2'd1;
          r_state <= ACC;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_r     = r_out_r;
  assign bus.out_i     = r_out_i;
  assign bus.out_bin   = r_out_bin;

endmodule

// File: tb/tb_qft_accumulator.sv
// Bench for qft_accumulator: directed frames plus randomized traffic, checked
// against a frame-level model that sums queued terms with plain arithmetic.
module tb_qft_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  qft_accumulator_if #(.DATA_W(13), .ACC_W(15)) bus ();

  qft_accumulator #(.N_TERMS(4), .DATA_W(13), .ACC_W(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state, describing the DUT after the most recent edge.
  int   m_qr[$];
  int   m_qi[$];
  int   m_bin;
  bit   m_pend;
  int   m_or, m_oi, m_ob;
  bit   m_live = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_qr.delete();
    m_qi.delete();
    m_bin  = 0;
    m_pend = 1'b0;
    m_or = 0; m_oi = 0; m_ob = 0;
  endtask

  // One clock cycle, entered and left on a falling edge.
  task automatic cycle(input logic v, input int r, input int i,
                       input logic ordy, input logic fl, input logic rn);
    bit exp_rdy, acc;
    int sr, si;
    if (m_live) begin
      chk("out_valid", bus.out_valid, m_pend);
      chk("out_r", $signed(bus.out_r), m_or);
      chk("out_i", $signed(bus.out_i), m_oi);
      chk("out_bin", bus.out_bin, m_ob);
    end
    rst_n        = rn;
    flush        = fl;
    bus.in_valid = v;
    bus.in_r     = 13'(r);
    bus.in_i     = 13'(i);
    bus.out_ready = ordy;
    #1;
    exp_rdy = !(m_qr.size() == 3 && m_pend && !ordy);
    if (rn && m_live) chk("in_ready", bus.in_ready, exp_rdy);
    if (!rn) begin
      model_reset();
      m_live = 1'b1;
    end else begin
      if (m_pend && ordy) m_pend = 1'b0;
      acc = v && exp_rdy && !fl;
      if (fl) begin
        m_qr.delete();
        m_qi.delete();
        m_bin = 0;
      end else if (acc) begin
        m_qr.push_back(r);
        m_qi.push_back(i);
        if (m_qr.size() == 4) begin
          sr = 0; si = 0;
          foreach (m_qr[k]) begin
            sr += m_qr[k];
            si += m_qi[k];
          end
          m_or = sr; m_oi = si; m_ob = m_bin;
          m_pend = 1'b1;
          m_bin = (m_bin + 1) % 4;
          m_qr.delete();
          m_qi.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  int tr[4] = '{100, 200, -50, 4095};
  int ti[4] = '{-5, 7, 3, -4096};

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_r = '0; bus.in_i = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_r", $signed(bus.out_r), 0);
    chk("rst_out_bin", bus.out_bin, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // Single reference frame
    for (int k = 0; k < 4; k++) cycle(1'b1, tr[k], ti[k], 1'b1, 1'b0, 1'b1);
    chk("f0_valid", bus.out_valid, 1);
    chk("f0_r", $signed(bus.out_r), 4345);
    chk("f0_i", $signed(bus.out_i), -4091);
    chk("f0_bin", bus.out_bin, 0);

    // Most negative frames, bin index wrap
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 4; k++) cycle(1'b1, -4096, -4096, 1'b1, 1'b0, 1'b1);
      chk("neg_r", $signed(bus.out_r), -16384);
      chk("neg_i", $signed(bus.out_i), -16384);
      chk("neg_bin", bus.out_bin, f % 4);
    end

    // Back-pressure on the closing term
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, tr[k], ti[k], 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 7 * k + 1, -3 * k, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 50, 60, 1'b0, 1'b0, 1'b1);
      chk("bp_ready", bus.in_ready, 0);
      chk("bp_hold_r", $signed(bus.out_r), 4345);
    end
    cycle(1'b1, 50, 60, 1'b1, 1'b0, 1'b1);
    chk("bp_f1_valid", bus.out_valid, 1);
    chk("bp_f1_r", $signed(bus.out_r), 1 + 8 + 15 + 50);
    chk("bp_f1_i", $signed(bus.out_i), -9 + 60);
    chk("bp_f1_bin", bus.out_bin, 1);

    // Flush drops partial frame and same-cycle term
    do_reset();
    cycle(1'b1, 500, 500, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 500, 500, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 900, 900, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1, 1, 1'b1, 1'b0, 1'b1);
    chk("fl_r", $signed(bus.out_r), 4);
    chk("fl_i", $signed(bus.out_i), 4);
    chk("fl_bin", bus.out_bin, 0);

    // Reset mid-frame with a pending result
    for (int k = 0; k < 4; k++) cycle(1'b1, 9, 9, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 9, 9, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 9, 9, 1'b0, 1'b0, 1'b1);
    do_reset();
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_r", $signed(bus.out_r), 0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 2, 3, 1'b1, 1'b0, 1'b1);
    chk("mr_bin", bus.out_bin, 0);
    chk("mr_r2", $signed(bus.out_r), 8);

    // Continuous back-to-back frames
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, k, -k, 1'b1, 1'b0, 1'b1);
      chk("b2b_valid", bus.out_valid, (k % 4) == 3);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic v, o, fl, rn;
      v  = ($urandom_range(3) != 0);
      o  = ($urandom_range(2) != 0);
      fl = ($urandom_range(40) == 0);
      rn = ($urandom_range(150) != 0);
      if ($urandom_range(3) == 0)
        cycle(v, ($urandom_range(1) != 0) ? 4095 : -4096,
              ($urandom_range(1) != 0) ? 4095 : -4096, o, fl, rn);
      else
        cycle(v, int'($urandom_range(8191)) - 4096,
              int'($urandom_range(8191)) - 4096, o, fl, rn);
    end
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
